// File: rtl/alu_decode_stage.sv
// ALU decode stage: RV32I ADD/SUB/AND/ADDI/ANDI decoder.
// One-entry registered output with valid/ready backpressure and flush.
package alu_decode_pkg;
  typedef enum logic [2:0] {
    F3_ADD = 3'b000,
    F3_AND = 3'b111
  } alu_funct3_e;

  typedef enum logic [6:0] {
    F7_BASE = 7'h00,
    F7_NEG  = 7'h20
  } alu_funct7_e;

  typedef struct packed {
    alu_funct3_e funct3;
    alu_funct7_e funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        we;
    logic        illegal;
  } id_ex_t;
endpackage

module alu_decode_stage
  import alu_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [31:0]     instr_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output alu_funct3_e     funct3_o,
  output alu_funct7_e     funct7_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] imm_o,
  output logic            use_imm_o,
  output logic            we_o,
  output logic            illegal_o,
  output logic            illegal_seen_o
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       is_op;
  logic       is_opi;
  logic       accept;
  logic       consume;
  logic       valid_q;
  logic       seen_q;
  id_ex_t     dec;
  id_ex_t     q;

  assign opc    = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];
  assign is_op  = (opc == 7'b0110011);
  assign is_opi = (opc == 7'b0010011);

  always_comb begin
    dec         = '0;
    dec.funct3  = F3_ADD;
    dec.funct7  = F7_BASE;
    dec.rs1     = instr_i[19:15];
    dec.rs2     = instr_i[24:20];
    dec.rd      = instr_i[11:7];
    dec.illegal = 1'b1;
    unique case (1'b1)
      is_op && f3 == 3'b000 && f7 == 7'h00: begin
        dec.illegal = 1'b0;
      end
      is_op && f3 == 3'b000 && f7 == 7'h20: begin
        dec.illegal = 1'b0;
        dec.funct7  = F7_NEG;
      end
      is_op && f3 == 3'b111 && f7 == 7'h00: begin
        dec.illegal = 1'b0;
        dec.funct3  = F3_AND;
      end
      is_opi && f3 == 3'b000: begin
        dec.illegal = 1'b0;
        dec.rs2     = '0;
        dec.use_imm = 1'b1;
        dec.imm     = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      is_opi && f3 == 3'b111: begin
        dec.illegal = 1'b0;
        dec.funct3  = F3_AND;
        dec.rs2     = '0;
        dec.use_imm = 1'b1;
        dec.imm     = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      default: begin
      end
    endcase
    // x0 is hardwired, so a write to it is suppressed
    dec.we = !dec.illegal && (dec.rd != 5'd0);
  end

  assign in_ready_o = !valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;
  assign consume    = valid_q && out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      seen_q  <= 1'b0;
      q       <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      q       <= dec;
      if (dec.illegal) seen_q <= 1'b1;
    end else if (consume) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid_o    = valid_q;
  assign funct3_o       = q.funct3;
  assign funct7_o       = q.funct7;
  assign rs1_o          = q.rs1;
  assign rs2_o          = q.rs2;
  assign rd_o           = q.rd;
  assign imm_o          = q.imm;
  assign use_imm_o      = q.use_imm;
  assign we_o           = q.we;
  assign illegal_o      = q.illegal;
  assign illegal_seen_o = seen_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: mnemonic-level model, random traffic,
// plus directed literal checks.
module tb_alu_decode_stage;
  import alu_decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  alu_funct3_e funct3;
  alu_funct7_e funct7;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic        use_imm, we, illegal, seen;

  int n_cmp = 0;
  int n_bad = 0;

  alu_decode_stage #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst), .instr_i(instr),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .flush_i(flush), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .funct3_o(funct3),
    .funct7_o(funct7), .rs1_o(rs1), .rs2_o(rs2),
    .rd_o(rd), .imm_o(imm), .use_imm_o(use_imm),
    .we_o(we), .illegal_o(illegal),
    .illegal_seen_o(seen)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          f3;
    int          f7;
    int          rs1;
    int          rs2;
    int          rd;
    logic [31:0] imm;
    bit          use_imm;
    bit          we;
    bit          ill;
  } exp_t;

  // Name the instruction first, then derive the fields from its meaning.
  function automatic exp_t model(logic [31:0] i);
    exp_t  e;
    string m;
    int    op, fn3, fn7;
    op  = int'(i[6:0]);
    fn3 = int'(i[14:12]);
    fn7 = int'(i[31:25]);
    m = "ILL";
    if (op == 51 && fn3 == 0 && fn7 == 0)  m = "ADD";
    if (op == 51 && fn3 == 0 && fn7 == 32) m = "SUB";
    if (op == 51 && fn3 == 7 && fn7 == 0)  m = "AND";
    if (op == 19 && fn3 == 0)              m = "ADDI";
    if (op == 19 && fn3 == 7)              m = "ANDI";
    e.rs1 = int'(i[19:15]);
    e.rs2 = int'(i[24:20]);
    e.rd  = int'(i[11:7]);
    e.f3 = (m == "AND" || m == "ANDI") ? 7 : 0;
    e.f7 = (m == "SUB") ? 32 : 0;
    e.use_imm = (m == "ADDI" || m == "ANDI");
    e.imm = 0;
    if (e.use_imm) begin
      e.imm = 32'($signed(i[31:20]));
      e.rs2 = 0;
    end
    e.ill = (m == "ILL");
    e.we  = !e.ill && e.rd != 0;
    return e;
  endfunction

  bit   m_valid = 0;
  bit   m_seen = 0;
  exp_t m_b;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 0;
      m_seen  = 0;
    end else begin
      if (flush) m_valid = 0;
      else if (in_valid && (!m_valid || out_ready)) begin
        m_valid = 1;
        m_b = model(instr);
        if (m_b.ill) m_seen = 1;
      end else if (m_valid && out_ready) m_valid = 0;
    end
  end

  always @(negedge clk) begin
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("illegal_seen", 32'(seen), 32'(m_seen));
    if (!rst) check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    if (!rst && m_valid) begin
      check("funct3", 32'(funct3), 32'(m_b.f3));
      check("funct7", 32'(funct7), 32'(m_b.f7));
      check("rs1", 32'(rs1), 32'(m_b.rs1));
      check("rs2", 32'(rs2), 32'(m_b.rs2));
      check("rd", 32'(rd), 32'(m_b.rd));
      check("imm", imm, m_b.imm);
      check("use_imm", 32'(use_imm), 32'(m_b.use_imm));
      check("we", 32'(we), 32'(m_b.we));
      check("illegal", 32'(illegal), 32'(m_b.ill));
    end
  end

  task automatic drive(logic [31:0] ins, logic v, logic ordy, logic fl);
    @(posedge clk);
    #1;
    instr = ins;
    in_valid = v;
    out_ready = ordy;
    flush = fl;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [4:0] a, b, d;
    logic [11:0] im;
    a  = 5'($urandom);
    b  = 5'($urandom);
    d  = 5'($urandom);
    im = 12'($urandom);
    case ($urandom_range(0, 7))
      0: return {7'h00, b, a, 3'b000, d, 7'h33};
      1: return {7'h20, b, a, 3'b000, d, 7'h33};
      2: return {7'h00, b, a, 3'b111, d, 7'h33};
      3: return {im, a, 3'b000, d, 7'h13};
      4: return {im, a, 3'b111, d, 7'h13};
      5: return {7'h20, b, a, 3'b111, d, 7'h33};
      6: return {7'($urandom), b, a, 3'($urandom), d, 7'h33};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    check("rst out_valid", 32'(out_valid), 0);
    check("rst seen", 32'(seen), 0);
    check("rst funct3", 32'(funct3), 0);
    check("rst imm", imm, 0);
    check("rst we", 32'(we), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post-rst in_ready", 32'(in_ready), 1);

    drive(32'h002081B3, 1, 1, 0);
    drive(32'h407302B3, 1, 1, 0);
    @(negedge clk);
    check("add valid", 32'(out_valid), 1);
    check("add rs1", 32'(rs1), 1);
    check("add rs2", 32'(rs2), 2);
    check("add rd", 32'(rd), 3);
    check("add we", 32'(we), 1);
    check("add f7", 32'(funct7), 0);
    drive(32'hFFF00093, 1, 1, 0);
    @(negedge clk);
    check("sub f7", 32'(funct7), 32'h20);
    check("sub rs1", 32'(rs1), 6);
    check("sub rd", 32'(rd), 5);
    drive(32'h0, 0, 1, 0);
    @(negedge clk);
    check("addi imm", imm, 32'hFFFFFFFF);
    check("addi use_imm", 32'(use_imm), 1);
    check("addi rs2", 32'(rs2), 0);
    check("addi rd", 32'(rd), 1);

    drive(32'h0F00F113, 1, 1, 0);
    drive(32'h002081B3, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall in_ready", 32'(in_ready), 0);
      check("stall funct3", 32'(funct3), 7);
      check("stall imm", imm, 32'h000000F0);
      check("stall rd", 32'(rd), 2);
    end
    drive(32'h002081B3, 1, 1, 0);
    @(negedge clk);
    check("release in_ready", 32'(in_ready), 1);
    drive(32'h0, 0, 1, 0);
    @(negedge clk);
    check("no bubble valid", 32'(out_valid), 1);
    check("no bubble rd", 32'(rd), 3);

    drive(32'h003160B3, 1, 1, 0);
    drive(32'h002081B3, 1, 1, 0);
    @(negedge clk);
    check("or illegal", 32'(illegal), 1);
    check("or we", 32'(we), 0);
    check("or seen", 32'(seen), 1);
    drive(32'h0, 0, 1, 0);
    @(negedge clk);
    check("seen sticky", 32'(seen), 1);
    check("legal after or", 32'(illegal), 0);

    drive(32'h00000013, 1, 1, 0);
    drive(32'h0, 0, 1, 0);
    @(negedge clk);
    check("x0 illegal", 32'(illegal), 0);
    check("x0 we", 32'(we), 0);

    drive(32'h002081B3, 1, 1, 0);
    drive(32'h407302B3, 1, 1, 1);
    @(negedge clk);
    check("pre-flush valid", 32'(out_valid), 1);
    drive(32'h0, 0, 1, 0);
    @(negedge clk);
    check("flush valid", 32'(out_valid), 0);

    for (int k = 0; k < 3000; k++)
      drive(rnd_instr(), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 19) == 0));

    drive(32'h002081B3, 1, 1, 0);
    drive(32'h0, 0, 0, 0);
    @(negedge clk);
    check("pre-rst valid", 32'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("async rst valid", 32'(out_valid), 0);
    check("async rst seen", 32'(seen), 0);
    check("async rst rd", 32'(rd), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("final in_ready", 32'(in_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
- Pipelined instruction decoder that produces the control fields consumed by the ALU: funct3/funct7 enums, register addresses, immediate and operand-select.
- Sits between fetch and execute.
- Accepts one 32-bit RV32I instruction per valid/ready handshake and presents the decoded bundle from a one-entry output register, with backpressure and flush.
- Supported ALU subset: ADD, SUB, AND, ADDI, ANDI. Everything else is flagged illegal.

Parameters:
- XLEN, 32, datapath/immediate width; only 32 is supported.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous, active-high reset
- instr_i  input  32  fetched instruction
- in_valid_i  input  1  instr_i valid
- in_ready_o  output  1  stage can accept instr_i this cycle
- flush_i  input  1  discard held and incoming instruction
- out_valid_o  output  1  decoded bundle valid
- out_ready_i  input  1  execute consumes bundle this cycle
- funct3_o  output  alu_funct3_e  ALU operation (ADD/AND)
- funct7_o  output  alu_funct7_e  NEG for SUB, non-NEG (7'b0) otherwise
- rs1_o  output  5  source register 1
- rs2_o  output  5  source register 2 (0 for immediate ops)
- rd_o  output  5  destination register
- imm_o  output  32  sign-extended I-immediate (0 for register ops)
- use_imm_o  output  1  operand_2 comes from imm_o, not rs2
- we_o  output  1  register write enable
- illegal_o  output  1  held instruction is unsupported
- illegal_seen_o  output  1  sticky: an illegal instruction was ever accepted

Behaviour:
- Reset (async, rst_i=1):
  - out_valid_o=0, illegal_seen_o=0.
  - All bundle outputs 0; funct3_o=ADD, funct7_o=non-NEG.
  - in_ready_o=1 once reset deasserts.
- Handshake:
  - in_ready_o = !out_valid_o || out_ready_i (combinational; no bubble under continuous flow).
  - Accept occurs when in_valid_i && in_ready_o.
  - Consume occurs when out_valid_o && out_ready_i.
- Latency: the bundle appears one cycle after accept.
  - Outputs are registered and stable while out_valid_o && !out_ready_i.
  - in_valid_i may drop without effect on held data.
- Next-state rules, in priority order:
  - flush_i: out_valid_o<=0 and the incoming instruction is dropped, even if accepted. in_ready_o is unaffected by flush_i. illegal_seen_o is not updated by a flushed instruction.
  - Accept: the register loads the decode of instr_i; out_valid_o<=1.
  - Consume without accept: out_valid_o<=0, bundle fields hold their values.
  - Otherwise: hold.
- Decode (opcode = instr[6:0]):
  - 0110011 (OP):
    - funct3 000 with funct7 0000000 -> ADD.
    - funct3 000 with funct7 0100000 -> ADD with funct7_o=NEG (SUB).
    - funct3 111 with funct7 0000000 -> AND.
    - rs1=[19:15], rs2=[24:20], rd=[11:7], use_imm=0, imm=0.
  - 0010011 (OP-IMM):
    - funct3 000 -> ADDI; 111 -> ANDI.
    - funct7_o non-NEG, imm = sign-extend instr[31:20], rs2=0, use_imm=1.
  - Any other opcode/funct3/funct7 combination (e.g. funct7 0100000 with funct3 111) -> illegal_o=1.
    - funct3_o=ADD, funct7_o non-NEG, we_o=0, use_imm=0, imm=0.
    - Register fields are still extracted raw.
- we_o = legal && rd != 0 (writes to x0 suppressed).
- illegal_seen_o is set on accept of an illegal instruction and cleared only by reset.
- Reset mid-transfer: the held bundle is lost; no output glitches beyond the async clear.

Test Plan:
- Reset, then 0x002081B3 (ADD x3,x1,x2) with out_ready_i=1 -> next cycle out_valid=1, funct3=ADD, funct7 non-NEG, rs1=1, rs2=2, rd=3, use_imm=0, we=1, illegal=0.
- 0x407302B3 (SUB x5,x6,x7) -> funct7=NEG, funct3=ADD, rs1=6, rs2=7, rd=5, we=1. Follow with 0xFFF00093 (ADDI x1,x0,-1) -> imm=0xFFFFFFFF, use_imm=1, rd=1, rs2=0.
- Hold out_ready_i=0 after 0x0F00F113 (ANDI x2,x1,0xF0) is accepted -> in_ready_o=0, bundle stable (funct3=AND, imm=0x000000F0) for 5 cycles. Present ADD at the input meanwhile; it is accepted only on the cycle out_ready_i rises, with zero bubble.
- 0x003160B3 (OR, unsupported) -> illegal_o=1, we_o=0, illegal_seen_o=1 and stays 1 after subsequent legal instructions until rst_i.
- ADDI with rd=0 (0x00000013) -> illegal=0, we_o=0.
- Assert flush_i in the same cycle as an accept -> out_valid_o=0 next cycle.
- Assert rst_i asynchronously while out_valid_o=1 -> out_valid_o drops immediately, without waiting for a clock edge.
